dense_layer_sequencer: RTL and testbench
========================================

// Module: dense_layer_sequencer
// PURPOSE
//   Front-end controller for the dense-layer datapath (120-way MAC array + serializer + sigmoid).
//   - Buffers one flattened input frame from the upstream layer (valid/ready).
//   - Replays the frame to the datapath as a gap-free ena burst, with frame_start/frame_end framing.
//   - Counts the datapath's serial outputs and reports frame completion and errors.
// PARAMETERS
//   DW          16    data width of input samples and datapath samples (signed)
//   N_IN        980   samples per input frame (dense fan-in)
//   AW          10    buffer address width; 2**AW >= N_IN
//   N_OUT       120   expected dp_valid pulses per frame (dense fan-out)
//   WDOG_CYCLES 4096  drain watchdog limit (used only with DENSE_SEQ_WDOG_EN)
// PORTS
//   clk              in   1    clock
//   rst              in   1    asynchronous reset, active-high
//   in_valid         in   1    upstream sample valid
//   in_data          in   DW   upstream sample
//   in_ready         out  1    sequencer can accept a sample
//   dp_ena           out  1    datapath enable; one sample per high cycle
//   dp_frame_start   out  1    high with the first sample of a burst
//   dp_frame_end     out  1    high with the last sample of a burst
//   dp_data          out  DW   sample to datapath, aligned with dp_ena
//   dp_valid         in   1    datapath serial output valid
//   dp_frame_end_out in   1    datapath end-of-output-frame strobe
//   busy             out  1    high in RUN or DRAIN
//   done             out  1    one-cycle pulse at frame completion
//   err_count        out  1    sticky: output count at frame end != N_OUT
//   err_timeout      out  1    sticky: watchdog expired (constant 0 without macro)
// BEHAVIOUR
//   - Reset (async, rst=1):
//     - All outputs 0; state FILL; wr_ptr=rd_ptr=out_cnt=0.
//     - in_ready rises the first clk edge after rst falls.
//   - All outputs are registered. Buffer: N_IN x DW single-port-per-side RAM, 1-cycle synchronous read.
//   - FILL:
//     - in_ready=1; transfer on in_valid & in_ready; in_data written at wr_ptr; wr_ptr++.
//     - On the transfer with wr_ptr==N_IN-1: in_ready=0 next cycle; go RUN; wr_ptr=0.
//     - Entering FILL from DRAIN: err_count/err_timeout clear on the first accepted sample.
//   - RUN:
//     - rd_ptr walks 0..N_IN-1, one read per cycle, no stalls.
//     - dp_ena is high for exactly N_IN consecutive cycles.
//     - First dp_ena cycle is 2 cycles after the last FILL transfer (RAM read + output register).
//     - dp_frame_start is high with sample 0 only; dp_frame_end is high with sample N_IN-1 only.
//     - After the last sample: go DRAIN; out_cnt=0.
//   - DRAIN:
//     - out_cnt++ on each dp_valid (saturates at 2**8-1).
//     - dp_valid outside DRAIN is ignored.
//     - On dp_frame_end_out, with any dp_valid in the same cycle counted:
//       - done=1 for one cycle;
//       - err_count=1 if the final count != N_OUT;
//       - go FILL; in_ready=1 next cycle.
//   - in_valid is ignored while in_ready=0; upstream must hold the sample.
//   - dp_frame_end_out seen in FILL/RUN: ignored, no error.
//   - busy = (state==RUN || state==DRAIN).
//   - rst asserted mid-frame: partial frame discarded, all state as after reset, no done pulse.
// CONFIGURATION
//   DENSE_SEQ_WDOG_EN defined:
//     - Counter runs in DRAIN, cleared on DRAIN entry.
//     - At WDOG_CYCLES with no dp_frame_end_out: err_timeout=1 (sticky), done=1 for one cycle, go FILL.
//   DENSE_SEQ_WDOG_EN undefined:
//     - No counter; err_timeout tied 0; DRAIN waits indefinitely.
// TESTING
//   1. Reset: rst=1 for 3 cycles, then 0 -> all outputs 0 during reset; in_ready=1 one cycle after release.
//   2. Ramp frame:
//      - Stimulus: in_data=0..979 back-to-back; datapath model gives 120 dp_valid, then dp_frame_end_out.
//      - Response: dp_ena high 980 cycles, starting 2 cycles after the last transfer; dp_data=0..979 in order.
//      - Response: frame_start with 0, frame_end with 979; done pulse; err_count=0.
//   3. Gappy upstream:
//      - Stimulus: in_valid toggled randomly, 50% duty.
//      - Response: exactly 980 transfers; dp_ena burst still contiguous; in_valid ignored in RUN/DRAIN.
//   4. Count error:
//      - Stimulus: model emits 119 dp_valid, then dp_frame_end_out.
//      - Response: done pulse; err_count=1 held until the next frame's first transfer.
//   5. Coincident events: dp_valid and dp_frame_end_out in the same cycle as the 120th output -> count=120, err_count=0.
//   6. Abort and watchdog:
//      - Stimulus: rst pulsed at sample 500 of RUN.
//        Response: outputs 0, next frame from sample 0.
//      - Stimulus (WDOG_EN, WDOG_CYCLES=64): no dp_frame_end_out.
//        Response: err_timeout=1 and done 64 cycles into DRAIN.

Source files
------------

// File: rtl/dense_layer_sequencer_if.sv
// Bundle between the dense-layer sequencer, its upstream layer and the MAC/sigmoid datapath.
// master = sequencer side, slave = upstream source plus datapath.
interface dense_layer_sequencer_if #(
    parameter int unsigned DW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          dp_ena;
    logic          dp_frame_start;
    logic          dp_frame_end;
    logic [DW-1:0] dp_data;
    logic          dp_valid;
    logic          dp_frame_end_out;
    logic          busy;
    logic          done;
    logic          err_count;
    logic          err_timeout;

    modport master (
        input  in_valid,
        input  in_data,
        input  dp_valid,
        input  dp_frame_end_out,
        output in_ready,
        output dp_ena,
        output dp_frame_start,
        output dp_frame_end,
        output dp_data,
        output busy,
        output done,
        output err_count,
        output err_timeout
    );

    modport slave (
        output in_valid,
        output in_data,
        output dp_valid,
        output dp_frame_end_out,
        input  in_ready,
        input  dp_ena,
        input  dp_frame_start,
        input  dp_frame_end,
        input  dp_data,
        input  busy,
        input  done,
        input  err_count,
        input  err_timeout
    );
endinterface

// File: rtl/dense_layer_sequencer.sv
// Dense-layer front end: buffers one input frame, replays it as a gap-free burst, counts outputs.
// Optional drain watchdog enabled by defining DENSE_SEQ_WDOG_EN.
module dense_layer_sequencer #(
    parameter int unsigned DW          = 16,
    parameter int unsigned N_IN        = 980,
    parameter int unsigned AW          = 10,
    parameter int unsigned N_OUT       = 120,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    dense_layer_sequencer_if.master bus
);
    localparam int unsigned   CW        = 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_IN - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_EXP   = CW'(N_OUT);

    // Elaboration-time sanity on the parameter set.
    if ((2 ** AW) < N_IN) begin : g_chk_aw
        $error("dense_layer_sequencer: AW too narrow for N_IN");
    end
    if (N_OUT > 255) begin : g_chk_nout
        $error("dense_layer_sequencer: N_OUT exceeds saturating output counter");
    end
    if (WDOG_CYCLES < 1) begin : g_chk_wdog
        $error("dense_layer_sequencer: WDOG_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_final;
    logic          wr_en;
    logic          rd_vld;
    logic          rd_first;
    logic          rd_last;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] mem [N_IN];

`ifdef DENSE_SEQ_WDOG_EN
    localparam int unsigned    WCW       = $clog2(WDOG_CYCLES + 1);
    localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_CYCLES - 1);
    logic [WCW-1:0] wdog_cnt;
`endif

    always_comb begin
        wr_en     = (state == S_FILL) && bus.in_valid && bus.in_ready;
        cnt_inc   = (out_cnt == CNT_MAX) ? out_cnt : out_cnt + CW'(1);
        cnt_final = bus.dp_valid ? cnt_inc : out_cnt;
    end

    // Frame buffer: one write port from upstream, one synchronous read port to the datapath.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.in_data;
        end
        rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_FILL;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            out_cnt            <= '0;
            rd_vld             <= 1'b0;
            rd_first           <= 1'b0;
            rd_last            <= 1'b0;
            bus.in_ready       <= 1'b0;
            bus.dp_ena         <= 1'b0;
            bus.dp_frame_start <= 1'b0;
            bus.dp_frame_end   <= 1'b0;
            bus.dp_data        <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.err_count      <= 1'b0;
            bus.err_timeout    <= 1'b0;
`ifdef DENSE_SEQ_WDOG_EN
            wdog_cnt           <= '0;
`endif
        end else begin
            rd_vld   <= 1'b0;
            rd_first <= 1'b0;
            rd_last  <= 1'b0;
            bus.done <= 1'b0;

            // Output stage lines up the RAM read with its framing flags.
            bus.dp_ena         <= rd_vld;
            bus.dp_frame_start <= rd_first;
            bus.dp_frame_end   <= rd_last;
            bus.dp_data        <= rd_vld ? rd_data : '0;

`ifndef DENSE_SEQ_WDOG_EN
            bus.err_timeout <= 1'b0;
`endif

            case (state)
                S_FILL: begin
                    bus.in_ready <= 1'b1;
                    if (wr_en) begin
                        // Errors from the previous frame stay visible until the new frame starts.
                        if (wr_ptr == '0) begin
                            bus.err_count   <= 1'b0;
                            bus.err_timeout <= 1'b0;
                        end
                        if (wr_ptr == LAST_ADDR) begin
                            wr_ptr       <= '0;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b1;
                            state        <= S_RUN;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end

                S_RUN: begin
                    rd_vld   <= 1'b1;
                    rd_first <= (rd_ptr == '0);
                    rd_last  <= (rd_ptr == LAST_ADDR);
                    if (rd_ptr == LAST_ADDR) begin
                        rd_ptr  <= '0;
                        out_cnt <= '0;
                        state   <= S_DRAIN;
`ifdef DENSE_SEQ_WDOG_EN
                        wdog_cnt <= '0;
`endif
                    end else begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end

                S_DRAIN: begin
                    if (bus.dp_valid) begin
                        out_cnt <= cnt_inc;
                    end
                    if (bus.dp_frame_end_out) begin
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.in_ready <= 1'b1;
                        state        <= S_FILL;
                        if (cnt_final != CNT_EXP) begin
                            bus.err_count <= 1'b1;
                        end
                    end
`ifdef DENSE_SEQ_WDOG_EN
                    else if (wdog_cnt == WDOG_LAST) begin
                        bus.err_timeout <= 1'b1;
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        bus.in_ready    <= 1'b1;
                        state           <= S_FILL;
                    end else begin
                        wdog_cnt <= wdog_cnt + WCW'(1);
                    end
`endif
                end

                default: begin
                    state        <= S_FILL;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Randomized self-checking bench for dense_layer_sequencer against a frame-level reference model.
module tb_dense_layer_sequencer;
    localparam int unsigned DW    = 16;
    localparam int unsigned N_IN  = 980;
    localparam int unsigned AW    = 10;
    localparam int unsigned N_OUT = 120;
`ifdef DENSE_SEQ_WDOG_EN
    localparam int unsigned WDOG  = 64;
`else
    localparam int unsigned WDOG  = 4096;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] exp_err_state = 2'b00;  // {err_count, err_timeout} expected before the next frame's first transfer

    int            ena_cyc[$];
    logic [DW-1:0] ena_data[$];
    bit            ena_st[$];
    bit            ena_en[$];
    int            done_cyc[$];
    int            stray = 0;
    int            ready_busy = 0;

    dense_layer_sequencer_if #(.DW(DW)) bus ();

    dense_layer_sequencer #(
        .DW(DW), .N_IN(N_IN), .AW(AW), .N_OUT(N_OUT), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.dp_ena) begin
                ena_cyc.push_back(cyc);
                ena_data.push_back(bus.dp_data);
                ena_st.push_back(bus.dp_frame_start);
                ena_en.push_back(bus.dp_frame_end);
            end else if (bus.dp_frame_start || bus.dp_frame_end) begin
                stray++;
            end
            if (bus.done) done_cyc.push_back(cyc);
            if (bus.in_ready && bus.busy) ready_busy++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({bus.in_ready, bus.dp_ena, bus.dp_frame_start, bus.dp_frame_end, bus.dp_data,
                    bus.busy, bus.done, bus.err_count, bus.err_timeout});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream keeps poking in_valid with junk while the sequencer is not accepting.
    task automatic idle_inputs(input bit gappy);
        bus.in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_data  = DW'($urandom);
    endtask

    // n_valid < 0 means the datapath never sends dp_frame_end_out (watchdog case).
    task automatic run_frame(input bit ramp, input bit gappy, input int n_valid,
                             input bit coinc, input int abort_at);
        logic [DW-1:0] frame [N_IN];
        int idx, guard, last_x, feo_cyc, ready_low, nbad, nst, nen, exp_cnt;
        bit vld, rdy, exp_err;

        for (int i = 0; i < N_IN; i++) frame[i] = ramp ? DW'(i) : DW'($urandom);
        ena_cyc.delete(); ena_data.delete(); ena_st.delete(); ena_en.delete();
        done_cyc.delete();
        stray = 0; ready_busy = 0; ready_low = 0; last_x = 0; feo_cyc = 0;

        check_val("err_hold", {bus.err_count, bus.err_timeout}, exp_err_state);

        idx = 0; guard = 0;
        while (idx < N_IN && guard < 20 * N_IN) begin
            vld = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = vld;
            bus.in_data  = frame[idx];
            rdy = bus.in_ready;
            if (!rdy) ready_low++;
            tick();
            guard++;
            if (vld && rdy) begin
                if (idx == 0) check_val("err_clear", {bus.err_count, bus.err_timeout}, 0);
                idx++;
                last_x = cyc;
            end
        end
        check_val("xfers", idx, N_IN);
        check_val("ready_fill", ready_low, 0);
        check_val("ready_drop", bus.in_ready, 0);
        check_val("busy_run", bus.busy, 1);

        // Burst: inject datapath strobes that must be ignored outside DRAIN.
        guard = 0;
        while (ena_cyc.size() < N_IN && guard < N_IN + 50) begin
            idle_inputs(gappy);
            bus.dp_valid         = (ena_cyc.size() >= 300 && ena_cyc.size() < 310);
            bus.dp_frame_end_out = (ena_cyc.size() == 400);
            if (abort_at >= 0 && ena_cyc.size() >= abort_at) break;
            tick();
            guard++;
        end
        bus.dp_valid = 1'b0;
        bus.dp_frame_end_out = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1;
            #1;
            check_val("abort_outs", outs_vec(), 0);
            tick();
            tick();
            rst = 1'b0;
            bus.in_valid = 1'b0;
            tick();
            check_val("abort_ready", bus.in_ready, 1);
            check_val("abort_no_done", done_cyc.size(), 0);
            exp_err_state = 2'b00;
            return;
        end

        check_val("ena_cnt", ena_cyc.size(), N_IN);
        nbad = 0; nst = 0; nen = 0;
        for (int i = 0; i < ena_data.size() && i < N_IN; i++) begin
            if (ena_data[i] !== frame[i]) nbad++;
            nst += int'(ena_st[i]);
            nen += int'(ena_en[i]);
        end
        check_val("dp_data", nbad, 0);
        check_val("start_cnt", nst, 1);
        check_val("end_cnt", nen, 1);
        check_val("stray_flags", stray, 0);
        if (ena_cyc.size() == N_IN) begin
            check_val("ena_first", ena_cyc[0], last_x + 2);
            check_val("ena_contig", ena_cyc[N_IN-1] - ena_cyc[0], N_IN - 1);
            check_val("start_pos", ena_st[0], 1);
            check_val("end_pos", ena_en[N_IN-1], 1);
        end
        check_val("no_early_done", done_cyc.size(), 0);
        check_val("busy_drain", bus.busy, 1);

`ifdef DENSE_SEQ_WDOG_EN
        if (n_valid < 0) begin
            guard = 0;
            while (done_cyc.size() == 0 && guard < WDOG + 100) begin
                idle_inputs(gappy);
                tick();
                guard++;
            end
            check_val("wdog_done_cnt", done_cyc.size(), 1);
            if (done_cyc.size() > 0) check_val("wdog_done_cyc", done_cyc[0], last_x + N_IN + WDOG);
            check_val("wdog_err", {bus.err_count, bus.err_timeout}, 2'b01);
            check_val("wdog_ready", bus.in_ready, 1);
            check_val("ready_busy", ready_busy, 0);
            exp_err_state = 2'b01;
            return;
        end
`endif

        // Datapath model: n_valid serial outputs, then end-of-output strobe.
        exp_cnt = (n_valid > 255) ? 255 : n_valid;
        exp_err = (exp_cnt != N_OUT);
        for (int i = 0; i < n_valid; i++) begin
            repeat ($urandom_range(0, 2)) begin idle_inputs(gappy); tick(); end
            bus.dp_valid = 1'b1;
            bus.dp_frame_end_out = coinc && (i == n_valid - 1);
            feo_cyc = cyc;
            tick();
            bus.dp_valid = 1'b0;
            bus.dp_frame_end_out = 1'b0;
        end
        if (!coinc) begin
            repeat ($urandom_range(1, 3)) begin idle_inputs(gappy); tick(); end
            bus.dp_frame_end_out = 1'b1;
            feo_cyc = cyc;
            tick();
            bus.dp_frame_end_out = 1'b0;
        end
        check_val("done", bus.done, 1);
        check_val("err_count", bus.err_count, exp_err);
        check_val("err_timeout", bus.err_timeout, 0);
        check_val("busy_idle", bus.busy, 0);
        check_val("ready_back", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        tick();
        check_val("done_pulse", bus.done, 0);
        check_val("done_once", done_cyc.size(), 1);
        if (done_cyc.size() == 1) check_val("done_cyc", done_cyc[0], feo_cyc + 1);
        check_val("ready_busy", ready_busy, 0);
        exp_err_state = {exp_err, 1'b0};
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.dp_valid = 1'b0;
        bus.dp_frame_end_out = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("reset_outs", outs_vec(), 0);
        end
        rst = 1'b0;
        check_val("ready_at_release", bus.in_ready, 0);
        tick();
        check_val("ready_after_reset", bus.in_ready, 1);
        check_val("busy_after_reset", bus.busy, 0);

        run_frame(1'b1, 1'b0, 120, 1'b0, -1);  // ramp frame
        run_frame(1'b0, 1'b1, 120, 1'b1, -1);  // gappy upstream, coincident last output
        run_frame(1'b0, 1'b1, 119, 1'b0, -1);  // short count
        run_frame(1'b0, 1'b0, 376, 1'b0, -1);  // counter saturates, still an error
        run_frame(1'b0, 1'b1, 121, 1'b1, -1);  // long count, coincident
        run_frame(1'b0, 1'b0, 120, 1'b0, 500); // reset mid-burst
        run_frame(1'b0, 1'b1, 120, 1'b0, -1);
`ifdef DENSE_SEQ_WDOG_EN
        run_frame(1'b0, 1'b0, -1, 1'b0, -1);   // no end-of-output strobe
        run_frame(1'b0, 1'b1, 120, 1'b1, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
